// File: rtl/crc16_serial_engine.sv
// crc16_serial_engine
// Multi-cycle CRC-16/CCITT-FALSE engine (non-reflected, MSB-first, no final XOR).
// One byte is accepted per handshake and folded in BITS_PER_CLK bits per clock,
// so a byte takes N = 8/BITS_PER_CLK busy cycles. The running CRC is published
// on crc_value only when a byte completes.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   crc_init       single-cycle pulse: reload INIT, abort any byte in flight
//   crc_data       byte to fold in, sampled only on the accept edge
//   crc_data_valid single-cycle request to process crc_data (ignored while busy)
//   crc_value      last completed CRC (registered)
//   crc_busy       high while a byte is in flight
//   crc_done       one-cycle pulse in the cycle after the last step of a byte
module crc16_serial_engine #(
  parameter logic [15:0] POLY         = 16'h1021,
  parameter logic [15:0] INIT         = 16'hFFFF,
  parameter int          BITS_PER_CLK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crc_init,
  input  logic [7:0]  crc_data,
  input  logic        crc_data_valid,
  output logic [15:0] crc_value,
  output logic        crc_busy,
  output logic        crc_done
);

  localparam int N  = 8 / BITS_PER_CLK;
  localparam int CW = $clog2(N + 1);

  // Only divisors of 8 give a whole number of steps per byte.
  generate
    if (!(BITS_PER_CLK == 1 || BITS_PER_CLK == 2 ||
          BITS_PER_CLK == 4 || BITS_PER_CLK == 8)) begin : g_bad_bits_per_clk
      $error("crc16_serial_engine: BITS_PER_CLK must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [15:0]     work_crc;
  logic [15:0]     crc_step;
  logic [7:0]      shift_reg;
  logic [7:0]      shift_step;
  logic [CW-1:0]   step_cnt;
  logic            accept;
  logic            last_step;
  logic            fb;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: init always wins, then accept, then stepping.
  always_comb begin
    state_next = state;
    if (crc_init) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if (crc_data_valid) state_next = SHIFT;
        SHIFT: if (last_step)      state_next = IDLE;
      endcase
    end
  end

  // FSM-derived controls. last_step marks the edge on which the counter reaches 0.
  always_comb begin
    crc_busy  = (state == SHIFT);
    accept    = (state == IDLE) && crc_data_valid && !crc_init;
    last_step = (state == SHIFT) && (step_cnt == CW'(1));
  end

  // BITS_PER_CLK iterations of the serial MSB-first update, unrolled into one clock.
  always_comb begin
    crc_step   = work_crc;
    shift_step = shift_reg;
    fb         = 1'b0;
    for (int i = 0; i < BITS_PER_CLK; i++) begin
      fb         = crc_step[15] ^ shift_step[7];
      crc_step   = {crc_step[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      shift_step = {shift_step[6:0], 1'b0};
    end
  end

  // Datapath: working CRC, byte shifter, step counter and the published result.
  // crc_value only moves on init or on the completion edge, so it is stable in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_crc  <= INIT;
      crc_value <= INIT;
      shift_reg <= 8'h00;
      step_cnt  <= '0;
      crc_done  <= 1'b0;
    end else if (crc_init) begin
      work_crc  <= INIT;
      crc_value <= INIT;
      step_cnt  <= '0;
      crc_done  <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      if (accept) begin
        shift_reg <= crc_data;
        step_cnt  <= CW'(N);
      end else if (state == SHIFT) begin
        work_crc  <= crc_step;
        shift_reg <= shift_step;
        if (step_cnt != '0) begin
          step_cnt <= step_cnt - CW'(1);
        end
        if (last_step) begin
          crc_value <= crc_step;
          crc_done  <= 1'b1;
        end
      end
    end
  end

endmodule
